// File: rtl/speculative_history_register_if.sv
// speculative_history_register_if: predict/resolve/flush signals and history outputs of the speculative history register
//   pred_valid/pred_taken/pred_ready : prediction push handshake
//   res_valid/res_taken              : in-order resolution of the oldest in-flight branch
//   flush                            : pipeline flush
//   spec_hist/arch_hist              : speculative and committed histories, bit 0 newest
//   count/recover                    : in-flight entry count, one-cycle mispredict-repair pulse
interface speculative_history_register_if #(
   parameter int HIST_W = 8,
   parameter int DEPTH  = 8
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic              pred_valid;
   logic              pred_taken;
   logic              pred_ready;
   logic              res_valid;
   logic              res_taken;
   logic              flush;
   logic [HIST_W-1:0] spec_hist;
   logic [HIST_W-1:0] arch_hist;
   logic [CW-1:0]     count;
   logic              recover;
   modport master (
      output pred_valid, pred_taken, res_valid, res_taken, flush,
      input  pred_ready, spec_hist, arch_hist, count, recover
   );
   modport slave (
      input  pred_valid, pred_taken, res_valid, res_taken, flush,
      output pred_ready, spec_hist, arch_hist, count, recover
   );
endinterface

// File: rtl/speculative_history_register.sv
// speculative_history_register: global branch history with speculative and committed copies and mispredict repair
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of speculative_history_register_if (predict push, resolve, flush, histories, count, recover)
module speculative_history_register #(
   parameter int HIST_W = 8,
   parameter int DEPTH  = 8
) (
   input logic                           clk,
   input logic                           rst_n,
   speculative_history_register_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [DEPTH-1:0]  fifo_q;
   logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [HIST_W-1:0] spec_q, spec_d, arch_q, arch_d;
   logic              recover_q;
   logic              res_ok, mispred, clear, push;
   always_comb begin
      res_ok   = bus.res_valid & (count_q != '0);
      mispred  = res_ok & (bus.res_taken != fifo_q[head_q]);
      clear    = bus.flush | mispred;
      // a correct resolve frees a slot this cycle, so a full FIFO can still accept
      bus.pred_ready = (count_q < CW'(DEPTH)) | res_ok;
      push     = bus.pred_valid & bus.pred_ready & ~clear;
      arch_d   = res_ok ? {arch_q[HIST_W-2:0], bus.res_taken} : arch_q;
      // repair always restores from the post-resolve committed history
      spec_d   = clear ? arch_d : push ? {spec_q[HIST_W-2:0], bus.pred_taken} : spec_q;
      count_d  = clear ? '0 : count_q + CW'(push) - CW'(res_ok);
      tail_d   = push ? tail_q + AW'(1) : tail_q;
      head_d   = clear ? tail_q : res_ok ? head_q + AW'(1) : head_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q    <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         spec_q    <= '0;
         arch_q    <= '0;
         recover_q <= 1'b0;
      end else begin
         if (push) fifo_q[tail_q] <= bus.pred_taken;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         spec_q    <= spec_d;
         arch_q    <= arch_d;
         recover_q <= mispred;
      end
   end
   assign bus.spec_hist = spec_q;
   assign bus.arch_hist = arch_q;
   assign bus.count     = count_q;
   assign bus.recover   = recover_q;
endmodule

// File: tb/tb_speculative_history_register.sv
// tb_speculative_history_register: directed and random checks of speculative_history_register against a queue-based model
module tb_speculative_history_register;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   fails = 0;
   bit   q[$];
   int   m_spec = 0, m_arch = 0, m_rec = 0;
   speculative_history_register_if #(.HIST_W(4), .DEPTH(4)) bus ();
   speculative_history_register #(.HIST_W(4), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_state(input string tag);
      chk({tag, ".spec"}, 32'(bus.spec_hist), m_spec);
      chk({tag, ".arch"}, 32'(bus.arch_hist), m_arch);
      chk({tag, ".count"}, 32'(bus.count), q.size());
      chk({tag, ".recover"}, 32'(bus.recover), m_rec);
   endtask
   task automatic step(input string tag, input bit pv, input bit pt, input bit rv, input bit rt, input bit fl);
      bit ready, res_ok, mis;
      bus.pred_valid = pv;
      bus.pred_taken = pt;
      bus.res_valid  = rv;
      bus.res_taken  = rt;
      bus.flush      = fl;
      ready = q.size() < 4 || (rv && q.size() != 0);
      #1 chk({tag, ".ready"}, 32'(bus.pred_ready), ready);
      @(posedge clk);
      res_ok = rv && q.size() != 0;
      mis = res_ok && rt != q[0];
      if (res_ok) begin
         m_arch = ((m_arch << 1) | rt) & 15;
         void'(q.pop_front());
      end
      if (fl || mis) begin
         m_spec = m_arch;
         q.delete();
      end else if (pv && ready) begin
         m_spec = ((m_spec << 1) | pt) & 15;
         q.push_back(pt);
      end
      m_rec = mis;
      #1 chk_state(tag);
   endtask
   initial begin
      bit pt;
      {bus.pred_valid, bus.pred_taken, bus.res_valid, bus.res_taken, bus.flush} = '0;
      #1 chk_state("reset");
      @(negedge clk) rst_n = 1'b1;
      // 1: fill with T,N,T,T then an extra push is dropped
      step("t1a", 1, 1, 0, 0, 0);
      step("t1b", 1, 0, 0, 0, 0);
      step("t1c", 1, 1, 0, 0, 0);
      step("t1d", 1, 1, 0, 0, 0);
      chk("t1.spec_const", 32'(bus.spec_hist), 32'hb);
      chk("t1.ready_full", 32'(bus.pred_ready), 0);
      step("t1drop", 1, 0, 0, 0, 0);
      chk("t1.spec_kept", 32'(bus.spec_hist), 32'hb);
      // 2: resolve T,N correctly
      step("t2a", 0, 0, 1, 1, 0);
      step("t2b", 0, 0, 1, 0, 0);
      chk("t2.arch_const", 32'(bus.arch_hist), 32'h2);
      // 3: resolve N against predicted T
      step("t3", 0, 0, 1, 0, 0);
      chk("t3.spec_const", 32'(bus.spec_hist), 32'h4);
      chk("t3.recover_const", 32'(bus.recover), 1);
      step("t3idle", 0, 0, 0, 0, 0);
      // 4: full FIFO, correct resolve plus push for 3 laps
      for (int i = 0; i < 4; i++) step("t4fill", 1, 1'($urandom), 0, 0, 0);
      for (int i = 0; i < 12; i++) step("t4lap", 1, 1'($urandom), 1, q[0], 0);
      chk("t4.count_const", 32'(bus.count), 4);
      // 5: flush with correct resolve at count 3, arch 0001
      step("t5f0", 0, 0, 0, 0, 1);
      step("t5a", 1, 1, 0, 0, 0);
      step("t5b", 0, 0, 1, 1, 0);
      step("t5c", 0, 0, 0, 0, 1);
      step("t5d", 0, 0, 0, 0, 0);
      m_arch = 0;
      // reach arch=0001 with count 3 from a clean committed history is not possible after a flush;
      // realign the model by resetting
      rst_n = 1'b0;
      q.delete(); m_spec = 0; m_rec = 0;
      @(negedge clk) rst_n = 1'b1;
      step("t5p", 1, 1, 0, 0, 0);
      step("t5r", 0, 0, 1, 1, 0);
      step("t5p1", 1, 1, 0, 0, 0);
      step("t5p2", 1, 0, 0, 0, 0);
      step("t5p3", 1, 1, 0, 0, 0);
      chk("t5.arch_pre", 32'(bus.arch_hist), 32'h1);
      step("t5flush", 1, 0, 1, 1, 1);
      chk("t5.arch_const", 32'(bus.arch_hist), 32'h3);
      chk("t5.spec_const", 32'(bus.spec_hist), 32'h3);
      chk("t5.recover_const", 32'(bus.recover), 0);
      step("t5empty_res", 0, 0, 1, 1, 0);
      // 6: async reset in the middle of a mispredict cycle
      step("t6p", 1, 1, 0, 0, 0);
      bus.pred_valid = 0;
      bus.res_valid  = 1;
      bus.res_taken  = 0;
      #2 rst_n = 1'b0;
      q.delete(); m_spec = 0; m_arch = 0; m_rec = 0;
      #1 chk_state("t6async");
      @(posedge clk);
      #1 chk_state("t6edge");
      bus.res_valid = 0;
      @(negedge clk) rst_n = 1'b1;
      // random phase
      for (int i = 0; i < 400; i++) begin
         pt = 1'($urandom);
         step("rnd", 1'($urandom), pt, 1'($urandom),
              (q.size() != 0 && $urandom_range(0, 4) != 0) ? q[0] : 1'($urandom),
              $urandom_range(0, 19) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
